pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 30 +++
 rtl/adder_slice.sv | 14 +
 rtl/pipelined_adder.sv | 102 ++++++++++
 tb/tb_pipelined_adder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: chunk-width helper and the record carried by each pipeline stage.
package adder_pkg;

  // Widest operand a stage record can hold; the top refuses wider configurations.
  localparam int MAX_WIDTH = 128;

  typedef logic [MAX_WIDTH-1:0] word_t;

  // One in-flight operation. Operands travel whole so later stages can pick
  // their chunk; s fills in one chunk per stage, low chunk first.
  typedef struct packed {
    logic  valid;  // entry holds a real operation (0 = bubble)
    logic  sub;    // 1 = subtract: B chunks are inverted as they are consumed
    logic  carry;  // carry out of the chunk added in this stage
    logic  ovf;    // signed overflow, only meaningful after the last stage
    word_t a;      // operand A, raw
    word_t b;      // operand B, raw (inversion applied per chunk)
    word_t s;      // partial sum, completed chunks at the bottom
  } stage_t;

  // Bits added per stage; 0 flags an unusable stage count.
  function automatic int chunk_width(input int width, input int stages);
    if (stages < 1) begin
      return 0;
    end else begin
      return width / stages;
    end
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: purely combinational W-bit adder with carry in and carry out.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked adder/subtractor with valid/ready flow control.
// Stage k adds chunk k using the carry registered by stage k-1; the final
// stage's register is the output register.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             valid_out,
  input  logic             ready_out
);

  localparam int C = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || WIDTH < 1 || WIDTH > MAX_WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES, at most MAX_WIDTH");
  end

  // The whole pipeline moves as one; it only stalls while a finished result
  // waits on a busy consumer.
  logic   advance_s;
  stage_t entry_s;

  assign advance_s = !valid_out || ready_out;
  assign ready_in  = advance_s;

  // Package the incoming operands as a stage-0 entry; subtract turns c_in
  // (a borrow) into the complementary carry.
  always_comb begin
    entry_s                = '0;
    entry_s.valid          = valid_in;
    entry_s.sub            = sub_in;
    entry_s.carry          = c_in ^ sub_in;
    entry_s.a[WIDTH-1:0]   = a_in;
    entry_s.b[WIDTH-1:0]   = b_in;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         in_s;
    stage_t         stage_d;
    stage_t         stage_q;
    logic [C-1:0]   b_eff_s;
    logic [C-1:0]   s_s;
    logic           cout_s;

    if (k == 0) begin : g_first
      assign in_s = entry_s;
    end else begin : g_next
      assign in_s = g_stage[k-1].stage_q;
    end

    assign b_eff_s = in_s.b[k*C +: C] ^ {C{in_s.sub}};

    adder_slice #(.W(C)) u_slice (
      .a_i    (in_s.a[k*C +: C]),
      .b_i    (b_eff_s),
      .cin_i  (in_s.carry),
      .s_o    (s_s),
      .cout_o (cout_s)
    );

    // Drop this stage's chunk into the partial sum, pass on its carry, and
    // on the last stage derive signed overflow from the top-bit signs.
    always_comb begin
      stage_d                = in_s;
      stage_d.s[k*C +: C]    = s_s;
      stage_d.carry          = cout_s;
      if (k == STAGES - 1) begin
        stage_d.ovf = (in_s.a[WIDTH-1] == b_eff_s[C-1]) && (s_s[C-1] != in_s.a[WIDTH-1]);
      end else begin
        stage_d.ovf = 1'b0;
      end
    end

    // Stage register: cleared by reset, shifts on advance, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= '0;
      end else if (advance_s) begin
        stage_q <= stage_d;
      end
    end
  end

  assign valid_out = g_stage[STAGES-1].stage_q.valid;
  assign sum       = g_stage[STAGES-1].stage_q.s[WIDTH-1:0];
  assign carry_out = g_stage[STAGES-1].stage_q.carry;
  assign overflow  = g_stage[STAGES-1].stage_q.ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks on an 8-bit/2-stage instance, latency and
// randomized checks on 32-bit/4-stage and 16-bit/1-stage instances.
module tb_pipelined_adder;

  logic clk;
  logic rst;

  logic [7:0]  a8, b8, s8;
  logic        c8, sub8, vi8, ri8, vo8, ro8, co8, ov8;
  logic [31:0] a32, b32, s32;
  logic        c32, sub32, vi32, ri32, vo32, ro32, co32, ov32;
  logic [15:0] a16, b16, s16;
  logic        c16, sub16, vi16, ri16, vo16, ro16, co16, ov16;

  int checks;
  int errors;

  typedef struct {
    longint unsigned s;
    bit              co;
    bit              ov;
  } exp_t;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .a_in(a8), .b_in(b8), .c_in(c8), .sub_in(sub8),
    .valid_in(vi8), .ready_in(ri8), .sum(s8), .carry_out(co8), .overflow(ov8),
    .valid_out(vo8), .ready_out(ro8));

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .a_in(a32), .b_in(b32), .c_in(c32), .sub_in(sub32),
    .valid_in(vi32), .ready_in(ri32), .sum(s32), .carry_out(co32), .overflow(ov32),
    .valid_out(vo32), .ready_out(ro32));

  pipelined_adder #(.WIDTH(16), .STAGES(1)) dut16 (
    .clk(clk), .rst(rst), .a_in(a16), .b_in(b16), .c_in(c16), .sub_in(sub16),
    .valid_in(vi16), .ready_in(ri16), .sum(s16), .carry_out(co16), .overflow(ov16),
    .valid_out(vo16), .ready_out(ro16));

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; overflow = true signed result out of range.
  function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b,
                                 input bit c, input bit sub);
    exp_t e;
    longint unsigned mask, half, cc;
    longint sa, sb, r;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    cc   = 64'(c);
    sa = (a >= half) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = (b >= half) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    if (!sub) begin
      e.s  = (a + b + cc) & mask;
      e.co = ((a + b + cc) >> w) != 64'd0;
      r    = sa + sb + longint'(cc);
    end else begin
      e.s  = (a - b - cc) & mask;
      e.co = (a >= b + cc);
      r    = sa - sb - longint'(cc);
    end
    e.ov = (r >= longint'(half)) || (r < -longint'(half));
    return e;
  endfunction

  function automatic longint unsigned pick(input int w);
    longint unsigned mask, half;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return half - 64'd1;
      3:       return half;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  task automatic idle8(input int n);
    vi8 = 1'b0;
    ro8 = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One 8-bit transfer, then stop at the sample point 2 edges after acceptance.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub,
                        output logic mid_vo);
    a8 = a; b8 = b; c8 = c; sub8 = sub; vi8 = 1'b1; ro8 = 1'b1;
    @(posedge clk); #1;
    vi8 = 1'b0;
    mid_vo = vo8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a8 = 8'hAA; b8 = 8'h55; vi8 = 1'b1; ro8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vo8 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vo8); end
    checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", s8); end
    checks++; if (co8 !== 1'b0 || ov8 !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", co8, ov8); end
    checks++; if (ri8 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ri8); end
    checks++; if (vo32 !== 1'b0 || vo16 !== 1'b0) begin errors++; $display("FAIL reset_valid_wide got=%b%b exp=00", vo32, vo16); end
    vi8 = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (ri8 !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", ri8); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    logic mid;
    idle8(3);
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, mid);
    checks++; if (mid !== 1'b0) begin errors++; $display("FAIL add_early_valid got=%b exp=0", mid); end
    checks++; if (vo8 !== 1'b1 || s8 !== 8'h00 || co8 !== 1'b1 || ov8 !== 1'b0)
      begin errors++; $display("FAIL add_ff_01 got v=%b s=%h c=%b o=%b exp v=1 s=00 c=1 o=0", vo8, s8, co8, ov8); end
    idle8(3);
    issue8(8'h0F, 8'h00, 1'b1, 1'b0, mid);
    checks++; if (vo8 !== 1'b1 || s8 !== 8'h10 || co8 !== 1'b0 || ov8 !== 1'b0)
      begin errors++; $display("FAIL add_cin got v=%b s=%h c=%b o=%b exp v=1 s=10 c=0 o=0", vo8, s8, co8, ov8); end
  endtask

  task automatic test_sub_borrow();
    logic mid;
    idle8(3);
    issue8(8'h05, 8'h07, 1'b0, 1'b1, mid);
    checks++; if (vo8 !== 1'b1 || s8 !== 8'hFE || co8 !== 1'b0 || ov8 !== 1'b0)
      begin errors++; $display("FAIL sub_05_07 got v=%b s=%h c=%b o=%b exp v=1 s=fe c=0 o=0", vo8, s8, co8, ov8); end
    idle8(3);
    issue8(8'h10, 8'h00, 1'b1, 1'b1, mid);
    checks++; if (vo8 !== 1'b1 || s8 !== 8'h0F || co8 !== 1'b1 || ov8 !== 1'b0)
      begin errors++; $display("FAIL sub_borrow_in got v=%b s=%h c=%b o=%b exp v=1 s=0f c=1 o=0", vo8, s8, co8, ov8); end
  endtask

  task automatic test_overflow();
    logic mid;
    idle8(3);
    issue8(8'h7F, 8'h01, 1'b0, 1'b0, mid);
    checks++; if (s8 !== 8'h80 || ov8 !== 1'b1 || co8 !== 1'b0)
      begin errors++; $display("FAIL ovf_add got s=%h c=%b o=%b exp s=80 c=0 o=1", s8, co8, ov8); end
    idle8(3);
    issue8(8'h80, 8'h01, 1'b0, 1'b1, mid);
    checks++; if (s8 !== 8'h7F || ov8 !== 1'b1 || co8 !== 1'b1)
      begin errors++; $display("FAIL ovf_sub got s=%h c=%b o=%b exp s=7f c=1 o=1", s8, co8, ov8); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] opa [3];
    logic [7:0] opb [3];
    logic [7:0] want [3];
    logic [7:0] got [$];
    int sent, stall;
    opa  = '{8'h10, 8'h20, 8'h30};
    opb  = '{8'h01, 8'h02, 8'h03};
    want = '{8'h11, 8'h22, 8'h33};
    idle8(3);
    sent = 0;
    stall = 0;
    for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
      if (sent < 3) begin
        a8 = opa[sent]; b8 = opb[sent]; c8 = 1'b0; sub8 = 1'b0; vi8 = 1'b1;
      end else begin
        vi8 = 1'b0;
      end
      if (vo8 && got.size() == 0 && stall < 3) begin
        ro8 = 1'b0;
        #1;
        checks++; if (ri8 !== 1'b0) begin errors++; $display("FAIL b2b_ready_in got=%b exp=0", ri8); end
        checks++; if (vo8 !== 1'b1 || s8 !== 8'h11) begin errors++; $display("FAIL b2b_hold got v=%b s=%h exp v=1 s=11", vo8, s8); end
        stall++;
      end else begin
        ro8 = 1'b1;
        #1;
        if (vo8) got.push_back(s8);
      end
      if (vi8 && ri8) sent++;
      @(posedge clk); #1;
    end
    vi8 = 1'b0;
    checks++; if (stall != 3) begin errors++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stall); end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL b2b_count got=%0d exp=3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic mid;
    idle8(3);
    a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; sub8 = 1'b0; vi8 = 1'b1; ro8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h03; b8 = 8'h04;
    @(posedge clk); #1;
    vi8 = 1'b0;
    ro8 = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (vo8 !== 1'b0 || s8 !== 8'h00) begin errors++; $display("FAIL midrst_clear got v=%b s=%h exp v=0 s=00", vo8, s8); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (ri8 !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ri8); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (vo8 !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc=%0d got=%b exp=0", i, vo8); end
    end
    issue8(8'h12, 8'h34, 1'b0, 1'b0, mid);
    checks++; if (vo8 !== 1'b1 || s8 !== 8'h46 || co8 !== 1'b0)
      begin errors++; $display("FAIL midrst_first got v=%b s=%h c=%b exp v=1 s=46 c=0", vo8, s8, co8); end
  endtask

  task automatic test_latency();
    int lat32, lat16;
    logic [31:0] r32;
    logic [15:0] r16;
    logic rc32, rc16;
    vi32 = 1'b0; ro32 = 1'b1; vi16 = 1'b0; ro16 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    a32 = 32'h89ABCDEF; b32 = 32'h76543211; c32 = 1'b0; sub32 = 1'b0; vi32 = 1'b1;
    a16 = 16'hFFFF;     b16 = 16'h0001;     c16 = 1'b1; sub16 = 1'b0; vi16 = 1'b1;
    @(posedge clk); #1;
    vi32 = 1'b0; vi16 = 1'b0;
    lat32 = -1; lat16 = -1;
    r32 = 32'h0; r16 = 16'h0; rc32 = 1'b0; rc16 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (vo32 && lat32 < 0) begin lat32 = i; r32 = s32; rc32 = co32; end
      if (vo16 && lat16 < 0) begin lat16 = i; r16 = s16; rc16 = co16; end
      @(posedge clk); #1;
    end
    checks++; if (lat32 != 4) begin errors++; $display("FAIL latency_32x4 got=%0d exp=4", lat32); end
    checks++; if (lat16 != 1) begin errors++; $display("FAIL latency_16x1 got=%0d exp=1", lat16); end
    checks++; if (r32 !== 32'h0 || rc32 !== 1'b1) begin errors++; $display("FAIL lat_value_32 got s=%h c=%b exp s=0 c=1", r32, rc32); end
    checks++; if (r16 !== 16'h0001 || rc16 !== 1'b1) begin errors++; $display("FAIL lat_value_16 got s=%h c=%b exp s=1 c=1", r16, rc16); end
  endtask

  task automatic random32(input int n);
    exp_t q [$];
    exp_t e;
    logic [31:0] prev_s;
    logic prev_hold, prev_co, prev_ov;
    prev_hold = 1'b0; prev_s = 32'h0; prev_co = 1'b0; prev_ov = 1'b0;
    for (int i = 0; i < n + 60; i++) begin
      if (i < n) begin
        a32 = 32'(pick(32)); b32 = 32'(pick(32));
        c32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
        vi32 = ($urandom_range(0, 3) != 0); ro32 = ($urandom_range(0, 3) != 0);
      end else begin
        vi32 = 1'b0; ro32 = 1'b1;
      end
      #1;
      checks++; if (ri32 !== (!vo32 || ro32)) begin errors++; $display("FAIL r32_ready got=%b exp=%b", ri32, (!vo32 || ro32)); end
      if (prev_hold) begin
        checks++;
        if (vo32 !== 1'b1 || s32 !== prev_s || co32 !== prev_co || ov32 !== prev_ov)
          begin errors++; $display("FAIL r32_hold got v=%b s=%h exp v=1 s=%h", vo32, s32, prev_s); end
      end
      if (vo32 && ro32) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL r32_extra got s=%h exp none", s32);
        end else begin
          e = q.pop_front();
          if (s32 !== e.s[31:0] || co32 !== e.co || ov32 !== e.ov)
            begin errors++; $display("FAIL r32_result got s=%h c=%b o=%b exp s=%h c=%b o=%b", s32, co32, ov32, e.s[31:0], e.co, e.ov); end
        end
      end
      if (vi32 && ri32) q.push_back(model(32, 64'(a32), 64'(b32), c32, sub32));
      prev_hold = vo32 && !ro32; prev_s = s32; prev_co = co32; prev_ov = ov32;
      @(posedge clk); #1;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL r32_drain got=%0d exp=0 pending", q.size()); end
  endtask

  task automatic random16(input int n);
    exp_t q [$];
    exp_t e;
    for (int i = 0; i < n + 20; i++) begin
      if (i < n) begin
        a16 = 16'(pick(16)); b16 = 16'(pick(16));
        c16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
        vi16 = ($urandom_range(0, 3) != 0); ro16 = ($urandom_range(0, 2) != 0);
      end else begin
        vi16 = 1'b0; ro16 = 1'b1;
      end
      #1;
      checks++; if (ri16 !== (!vo16 || ro16)) begin errors++; $display("FAIL r16_ready got=%b exp=%b", ri16, (!vo16 || ro16)); end
      if (vo16 && ro16) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL r16_extra got s=%h exp none", s16);
        end else begin
          e = q.pop_front();
          if (s16 !== e.s[15:0] || co16 !== e.co || ov16 !== e.ov)
            begin errors++; $display("FAIL r16_result got s=%h c=%b o=%b exp s=%h c=%b o=%b", s16, co16, ov16, e.s[15:0], e.co, e.ov); end
        end
      end
      if (vi16 && ri16) q.push_back(model(16, 64'(a16), 64'(b16), c16, sub16));
      @(posedge clk); #1;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL r16_drain got=%0d exp=0 pending", q.size()); end
  endtask

  task automatic test_random();
    fork
      random32(500);
      random16(500);
    join
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
    a8 = '0;  b8 = '0;  c8 = 1'b0;  sub8 = 1'b0;  vi8 = 1'b0;  ro8 = 1'b0;
    a32 = '0; b32 = '0; c32 = 1'b0; sub32 = 1'b0; vi32 = 1'b0; ro32 = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0; sub16 = 1'b0; vi16 = 1'b0; ro16 = 1'b0;
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
